// File: rtl/repairmb_lane_ctrl_if.sv
// Sideband message and D2C test handshake between the lane-repair controller
// (master) and the sideband / test-engine side (slave).
interface repairmb_lane_ctrl_if #(
  parameter int NUM_LANES  = 16,
  parameter int NUM_GROUPS = 2
);
  logic [3:0]            i_rx_msg;
  logic                  i_rx_msg_valid;
  logic                  i_sb_busy;
  logic                  i_d2c_done;
  logic [NUM_LANES-1:0]  i_lane_results;
  logic [3:0]            o_tx_msg;
  logic                  o_tx_valid;
  logic [NUM_GROUPS-1:0] o_tx_info;
  logic                  o_d2c_en;

  modport master (
    input  i_rx_msg, i_rx_msg_valid, i_sb_busy, i_d2c_done, i_lane_results,
    output o_tx_msg, o_tx_valid, o_tx_info, o_d2c_en
  );

  modport slave (
    output i_rx_msg, i_rx_msg_valid, i_sb_busy, i_d2c_done, i_lane_results,
    input  o_tx_msg, o_tx_valid, o_tx_info, o_d2c_en
  );
endinterface

// File: rtl/repairmb_lane_ctrl.sv
// MBINIT repair step: tests mainband lanes, degrades to passing lane groups
// through a sideband req/resp exchange, and reports done or error.
//
// state      | meaning
// -----------+--------------------------------------------------------
// IDLE       | waiting for i_start
// SEND_START | sending start_req once sideband is free
// WAIT_START | waiting for start_resp (timed)
// D2C        | D2C test requested, waiting for i_d2c_done
// EVAL       | judging captured group mask
// SEND_DEG   | sending degrade_req with the reduced mask
// WAIT_DEG   | waiting for degrade_resp (timed)
// SEND_END   | sending end_req
// WAIT_END   | waiting for end_resp (timed)
// DONE       | success, holds o_done until i_start drops
// ERROR      | failure, holds o_error until i_start drops
module repairmb_lane_ctrl #(
  parameter int NUM_LANES   = 16,
  parameter int NUM_GROUPS  = 2,
  parameter int MAX_RETRY   = 2,
  parameter int TIMEOUT_CYC = 1024,
  localparam int RCW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
  input  logic                   CLK,
  input  logic                   rst_n,
  input  logic                   i_start,
  repairmb_lane_ctrl_if.master   bus,
  output logic [NUM_GROUPS-1:0]  o_func_groups,
  output logic [RCW-1:0]         o_retry_cnt,
  output logic                   o_done,
  output logic                   o_error
);
  localparam int LPG = NUM_LANES / NUM_GROUPS;
  localparam int TCW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TCW-1:0] TMO_LOAD = TCW'(TIMEOUT_CYC - 1);
  localparam logic [NUM_GROUPS-1:0] ALL_ON = '1;

  localparam logic [3:0] MSG_START_REQ  = 4'd1;
  localparam logic [3:0] MSG_START_RESP = 4'd2;
  localparam logic [3:0] MSG_END_REQ    = 4'd3;
  localparam logic [3:0] MSG_END_RESP   = 4'd4;
  localparam logic [3:0] MSG_DEG_REQ    = 4'd5;
  localparam logic [3:0] MSG_DEG_RESP   = 4'd6;

  typedef enum logic [3:0] {
    S_IDLE, S_SEND_START, S_WAIT_START, S_D2C, S_EVAL, S_SEND_DEG,
    S_WAIT_DEG, S_SEND_END, S_WAIT_END, S_DONE, S_ERROR
  } state_t;

  state_t                state_q, state_d;
  logic [3:0]            tx_msg_q, tx_msg_d;
  logic                  tx_valid_q, tx_valid_d;
  logic [NUM_GROUPS-1:0] tx_info_q, tx_info_d;
  logic                  d2c_en_q;
  logic [NUM_GROUPS-1:0] func_q, func_d;
  logic [NUM_GROUPS-1:0] mask_q, mask_d;
  logic [RCW-1:0]        retry_q, retry_d;
  logic                  done_q, error_q;
  logic [TCW-1:0]        tmo_q, tmo_d;
  logic [NUM_GROUPS-1:0] grp_pass;
  logic                  rx_start_resp, rx_deg_resp, rx_end_resp, tmo_expired;

  always_comb begin
    grp_pass = '0;
    for (int g = 0; g < NUM_GROUPS; g++)
      grp_pass[g] = &bus.i_lane_results[g*LPG +: LPG];
  end

  assign rx_start_resp = bus.i_rx_msg_valid && (bus.i_rx_msg == MSG_START_RESP);
  assign rx_deg_resp   = bus.i_rx_msg_valid && (bus.i_rx_msg == MSG_DEG_RESP);
  assign rx_end_resp   = bus.i_rx_msg_valid && (bus.i_rx_msg == MSG_END_RESP);
  assign tmo_expired   = (tmo_q == '0);

  always_comb begin
    state_d    = state_q;
    tx_msg_d   = tx_msg_q;
    tx_valid_d = 1'b0;
    tx_info_d  = tx_info_q;
    func_d     = func_q;
    mask_d     = mask_q;
    retry_d    = retry_q;
    tmo_d      = tmo_q;
    if (!i_start) begin
      // abort wins over everything, including a send decided this cycle
      state_d = S_IDLE;
      func_d  = ALL_ON;
      retry_d = '0;
      tmo_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: state_d = S_SEND_START;
        S_SEND_START:
          if (!bus.i_sb_busy) begin
            tx_valid_d = 1'b1;
            tx_msg_d   = MSG_START_REQ;
            tx_info_d  = func_q;
            tmo_d      = TMO_LOAD;
            state_d    = S_WAIT_START;
          end
        S_WAIT_START:
          if (rx_start_resp)    state_d = S_D2C;
          else if (tmo_expired) state_d = S_ERROR;
          else                  tmo_d   = tmo_q - TCW'(1);
        S_D2C:
          if (bus.i_d2c_done) begin
            mask_d  = grp_pass & func_q;
            state_d = S_EVAL;
          end
        S_EVAL:
          if (mask_q == '0)                    state_d = S_ERROR;
          else if (mask_q == func_q)           state_d = S_SEND_END;
          else if (retry_q == RCW'(MAX_RETRY)) state_d = S_ERROR;
          else begin
            func_d  = mask_q;
            retry_d = retry_q + RCW'(1);
            state_d = S_SEND_DEG;
          end
        S_SEND_DEG:
          if (!bus.i_sb_busy) begin
            tx_valid_d = 1'b1;
            tx_msg_d   = MSG_DEG_REQ;
            tx_info_d  = func_q;
            tmo_d      = TMO_LOAD;
            state_d    = S_WAIT_DEG;
          end
        S_WAIT_DEG:
          if (rx_deg_resp)      state_d = S_D2C;
          else if (tmo_expired) state_d = S_ERROR;
          else                  tmo_d   = tmo_q - TCW'(1);
        S_SEND_END:
          if (!bus.i_sb_busy) begin
            tx_valid_d = 1'b1;
            tx_msg_d   = MSG_END_REQ;
            tx_info_d  = func_q;
            tmo_d      = TMO_LOAD;
            state_d    = S_WAIT_END;
          end
        S_WAIT_END:
          if (rx_end_resp)      state_d = S_DONE;
          else if (tmo_expired) state_d = S_ERROR;
          else                  tmo_d   = tmo_q - TCW'(1);
        S_DONE:  state_d = S_DONE;
        S_ERROR: state_d = S_ERROR;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // status levels are registered from the next state so they line up with it
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      tx_msg_q   <= '0;
      tx_valid_q <= 1'b0;
      tx_info_q  <= '0;
      d2c_en_q   <= 1'b0;
      func_q     <= ALL_ON;
      mask_q     <= '0;
      retry_q    <= '0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      tmo_q      <= '0;
    end else begin
      state_q    <= state_d;
      tx_msg_q   <= tx_msg_d;
      tx_valid_q <= tx_valid_d;
      tx_info_q  <= tx_info_d;
      d2c_en_q   <= (state_d == S_D2C);
      func_q     <= func_d;
      mask_q     <= mask_d;
      retry_q    <= retry_d;
      done_q     <= (state_d == S_DONE);
      error_q    <= (state_d == S_ERROR);
      tmo_q      <= tmo_d;
    end
  end

  assign bus.o_tx_msg   = tx_msg_q;
  assign bus.o_tx_valid = tx_valid_q;
  assign bus.o_tx_info  = tx_info_q;
  assign bus.o_d2c_en   = d2c_en_q;
  assign o_func_groups  = func_q;
  assign o_retry_cnt    = retry_q;
  assign o_done         = done_q;
  assign o_error        = error_q;
endmodule

// File: tb/tb_repairmb_lane_ctrl.sv
// Randomized bench for repairmb_lane_ctrl; expected outcome of every flow is
// derived from the group pass/fail rules applied to the result vectors.
module tb_repairmb_lane_ctrl;
  localparam int NL  = 16;
  localparam int NG  = 2;
  localparam int MR  = 2;
  localparam int TO  = 1024;
  localparam int LPG = NL / NG;
  localparam int RCW = (MR > 0) ? $clog2(MR + 1) : 1;
  localparam int ALL = (1 << NG) - 1;
  localparam int LANE_ONES = (1 << LPG) - 1;

  logic          CLK = 1'b0;
  logic          rst_n = 1'b1;
  logic          i_start = 1'b0;
  logic [NG-1:0] o_func_groups;
  logic [RCW-1:0] o_retry_cnt;
  logic          o_done, o_error;
  int n_tests = 0;
  int n_fail = 0;
  int tx_total = 0;

  repairmb_lane_ctrl_if #(.NUM_LANES(NL), .NUM_GROUPS(NG)) bus ();

  repairmb_lane_ctrl #(.NUM_LANES(NL), .NUM_GROUPS(NG), .MAX_RETRY(MR), .TIMEOUT_CYC(TO)) dut (
    .CLK(CLK), .rst_n(rst_n), .i_start(i_start), .bus(bus),
    .o_func_groups(o_func_groups), .o_retry_cnt(o_retry_cnt),
    .o_done(o_done), .o_error(o_error)
  );

  always #5 CLK = ~CLK;
  always @(negedge CLK) if (bus.o_tx_valid === 1'b1) tx_total++;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // reference: a group is usable only if every lane in it passed and it was already enabled
  function automatic int exp_mask(input logic [NL-1:0] r, input int f);
    int m = 0;
    for (int g = 0; g < NG; g++)
      if (((r >> (g*LPG)) & NL'(LANE_ONES)) == NL'(LANE_ONES)) m = m | (1 << g);
    return m & f;
  endfunction

  function automatic logic [NL-1:0] gen_res();
    logic [NL-1:0] r = '1;
    for (int g = 0; g < NG; g++)
      if ($urandom_range(0, 3) == 0) r[g*LPG + int'($urandom_range(0, LPG-1))] = 1'b0;
    return r;
  endfunction

  task automatic wait_tx(input string tag, input int code, input int info, input bit chk_info,
                         input int busy_cyc);
    bit seen = 1'b0;
    bus.i_sb_busy = (busy_cyc > 0);
    for (int c = 0; c < 200; c++) begin
      tick();
      if (bus.o_tx_valid) begin
        seen = 1'b1;
        break;
      end
      if (c + 1 >= busy_cyc) bus.i_sb_busy = 1'b0;
    end
    bus.i_sb_busy = 1'b0;
    check_val({tag, "_seen"}, 32'(seen), 1);
    check_val({tag, "_code"}, 32'(bus.o_tx_msg), 32'(code));
    if (chk_info) check_val({tag, "_info"}, 32'(bus.o_tx_info), 32'(info));
    tick();
    check_val({tag, "_len"}, 32'(bus.o_tx_valid), 0);
  endtask

  task automatic respond(input int code, input int lat, input bit junk);
    for (int i = 0; i < lat; i++) begin
      if (junk && ($urandom_range(0, 2) == 0)) begin
        bus.i_rx_msg = 4'((code + int'($urandom_range(1, 15))) % 16);
        bus.i_rx_msg_valid = 1'b1;
      end else bus.i_rx_msg_valid = 1'b0;
      tick();
    end
    bus.i_rx_msg = 4'(code);
    bus.i_rx_msg_valid = 1'b1;
    tick();
    bus.i_rx_msg_valid = 1'b0;
    bus.i_rx_msg = 4'($urandom);
  endtask

  task automatic run_d2c(input string tag, input logic [NL-1:0] r, input int dly);
    bit seen = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (bus.o_d2c_en) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    check_val({tag, "_d2c_en"}, 32'(seen), 1);
    for (int i = 0; i < dly; i++) tick();
    check_val({tag, "_d2c_hold"}, 32'(bus.o_d2c_en), 1);
    bus.i_lane_results = r;
    bus.i_d2c_done = 1'b1;
    tick();
    bus.i_d2c_done = 1'b0;
    bus.i_lane_results = NL'($urandom);
    check_val({tag, "_d2c_drop"}, 32'(bus.o_d2c_en), 0);
  endtask

  task automatic wait_status(input string tag, input bit exp_done);
    bit seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (o_done || o_error) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    check_val({tag, "_status"}, 32'(seen), 1);
    check_val({tag, "_done"}, 32'(o_done), 32'(exp_done));
    check_val({tag, "_error"}, 32'(o_error), 32'(!exp_done));
  endtask

  task automatic run_flow(input string tag, input logic [NL-1:0] r0, input logic [NL-1:0] r1,
                          input logic [NL-1:0] r2, input bit rnd);
    logic [NL-1:0] res [3];
    int f, m, retry, sends, base;
    bit exp_done;
    res[0] = r0; res[1] = r1; res[2] = r2;
    f = ALL; retry = 0; sends = 1; exp_done = 1'b0; base = tx_total;
    i_start = 1'b1;
    wait_tx({tag, "_start_req"}, 1, 0, 1'b0, rnd ? int'($urandom_range(0, 6)) : 0);
    respond(2, rnd ? int'($urandom_range(0, 30)) : 1, rnd);
    for (int rd = 0; rd <= MR; rd++) begin
      run_d2c(tag, res[rd], rnd ? int'($urandom_range(0, 4)) : 0);
      m = exp_mask(res[rd], f);
      if (m == 0) break;
      if (m == f) begin
        wait_tx({tag, "_end_req"}, 3, 0, 1'b0, rnd ? int'($urandom_range(0, 6)) : 0);
        sends++;
        respond(4, rnd ? int'($urandom_range(0, 30)) : 1, rnd);
        exp_done = 1'b1;
        break;
      end
      if (retry == MR) break;
      f = m;
      retry++;
      wait_tx({tag, "_deg_req"}, 5, m, 1'b1, rnd ? int'($urandom_range(0, 6)) : 0);
      sends++;
      respond(6, rnd ? int'($urandom_range(0, 30)) : 1, rnd);
    end
    wait_status(tag, exp_done);
    check_val({tag, "_func"}, 32'(o_func_groups), 32'(f));
    check_val({tag, "_retry"}, 32'(o_retry_cnt), 32'(retry));
    check_val({tag, "_sends"}, 32'(tx_total - base), 32'(sends));
    i_start = 1'b0;
    tick();
    check_val({tag, "_abort_done"}, 32'(o_done | o_error), 0);
    check_val({tag, "_abort_func"}, 32'(o_func_groups), ALL);
    check_val({tag, "_abort_retry"}, 32'(o_retry_cnt), 0);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1);
  end

  initial begin
    int n, base;
    bit quiet;
    bus.i_rx_msg = '0; bus.i_rx_msg_valid = 1'b0; bus.i_sb_busy = 1'b0;
    bus.i_d2c_done = 1'b0; bus.i_lane_results = '0;
    #2 rst_n = 1'b0;
    #10;
    check_val("rst_tx_msg", 32'(bus.o_tx_msg), 0);
    check_val("rst_tx_valid", 32'(bus.o_tx_valid), 0);
    check_val("rst_tx_info", 32'(bus.o_tx_info), 0);
    check_val("rst_d2c_en", 32'(bus.o_d2c_en), 0);
    check_val("rst_func", 32'(o_func_groups), ALL);
    check_val("rst_retry", 32'(o_retry_cnt), 0);
    check_val("rst_done_err", 32'({o_done, o_error}), 0);
    @(negedge CLK) rst_n = 1'b1;
    tick();

    run_flow("all_pass", 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b0);
    run_flow("lane3", 16'hFFF7, 16'hFF00, 16'hFFFF, 1'b0);
    run_flow("both_fail", 16'h7FFE, 16'hFFFF, 16'hFFFF, 1'b0);

    // no response at all: error exactly TO cycles after entering WAIT_START
    i_start = 1'b1;
    wait_tx("tmo_start", 1, 0, 1'b0, 0);
    n = 1;
    while (!o_error && n < TO + 20) begin
      tick();
      n++;
    end
    check_val("tmo_cycles", 32'(n), 32'(TO));
    i_start = 1'b0;
    tick();

    // response landing in the expiry cycle is still accepted
    i_start = 1'b1;
    wait_tx("tmo_edge_start", 1, 0, 1'b0, 0);
    respond(2, TO - 2, 1'b0);
    check_val("tmo_edge_d2c", 32'(bus.o_d2c_en), 1);
    check_val("tmo_edge_err", 32'(o_error), 0);
    i_start = 1'b0;
    tick();

    // sideband busy while a degrade is pending, then abort in WAIT_DEG
    i_start = 1'b1;
    wait_tx("busy_start", 1, 0, 1'b0, 0);
    respond(2, 1, 1'b0);
    bus.i_sb_busy = 1'b1;
    run_d2c("busy", 16'hFFF7, 0);
    base = tx_total;
    quiet = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.o_tx_valid) quiet = 1'b0;
    end
    check_val("busy_quiet", 32'(quiet), 1);
    bus.i_sb_busy = 1'b0;
    tick();
    check_val("busy_strobe", 32'(bus.o_tx_valid), 1);
    check_val("busy_code", 32'(bus.o_tx_msg), 5);
    check_val("busy_info", 32'(bus.o_tx_info), 2);
    tick();
    check_val("busy_once", 32'(tx_total - base), 1);
    check_val("busy_retry", 32'(o_retry_cnt), 1);
    i_start = 1'b0;
    tick();
    check_val("abort_func", 32'(o_func_groups), ALL);
    check_val("abort_retry", 32'(o_retry_cnt), 0);
    check_val("abort_d2c", 32'(bus.o_d2c_en), 0);

    // asynchronous reset mid-test, observed before any clock edge
    i_start = 1'b1;
    wait_tx("arst_start", 1, 0, 1'b0, 0);
    respond(2, 1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check_val("arst_d2c", 32'(bus.o_d2c_en), 0);
    check_val("arst_tx_msg", 32'(bus.o_tx_msg), 0);
    check_val("arst_func", 32'(o_func_groups), ALL);
    i_start = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 40; i++) run_flow("rnd", gen_res(), gen_res(), gen_res(), 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
